cpu_multicycle_control: RTL and testbench

Multi-cycle control unit for the 16-bit CPU. Sequences FETCH/DECODE/EXEC/MEM/WB and drives the ALU result-mux select, operand controls, register-file, memory and PC enables. Sits between the instruction register (opcode) and the datapath. Includes a memory-wait timeout that traps to a sticky fault state.

---
 rtl/cpu_multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_cpu_multicycle_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_control.sv
// Multi-cycle control unit for the 16-bit CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB and decodes datapath controls from the
// current state and the latched opcode. A memory-wait timeout in FETCH or MEM
// traps into a sticky FAULT state that only reset leaves.
module cpu_multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       MemReady,
  input  logic       Zero,
  output logic [2:0] AluSel,
  output logic       BInvert,
  output logic       CarryIn,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IllegalOp,
  output logic       Fault,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_LW   = 4'b1000,
    OP_SW   = 4'b1001,
    OP_BEQ  = 4'b1010,
    OP_ADDI = 4'b1011,
    OP_HALT = 4'b1111
  } op_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wait_expired;
  logic              opcode_legal;

  // Opcode legality of the live instruction-register value (used in DECODE).
  always_comb begin
    opcode_legal = 1'b1;
    case (Opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_SLL,
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_HALT: opcode_legal = 1'b1;
      default:                                opcode_legal = 1'b0;
    endcase
  end

  assign wait_expired = (MEM_WAIT_MAX != 0) && (wait_q == WAIT_W'(MEM_WAIT_MAX));

  // State, latched opcode and wait counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, opcode latch and wait-counter update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (MemReady)          state_d = S_DECODE;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        op_d = Opcode;
        if (Opcode == OP_HALT)  state_d = S_HALT;
        else if (!opcode_legal) state_d = S_FETCH;
        else                    state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ:       state_d = S_FETCH;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (MemReady)          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
    // Counter only runs while a memory transfer is stalled in place.
    if ((state_q == S_FETCH || state_q == S_MEM) && !MemReady && state_d == state_q)
      wait_d = wait_q + WAIT_W'(1);
  end

  // Output decode from state and latched opcode.
  always_comb begin
    AluSel    = '0;
    BInvert   = 1'b0;
    CarryIn   = 1'b0;
    ALUSrc    = 1'b0;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    IllegalOp = 1'b0;
    Fault     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: IllegalOp = !opcode_legal;
      S_EXEC: begin
        case (op_q)
          OP_AND:  AluSel = 3'b000;
          OP_OR:   AluSel = 3'b010;
          OP_XOR:  AluSel = 3'b011;
          OP_SLT:  AluSel = 3'b110;
          OP_SLL:  AluSel = 3'b111;
          default: AluSel = 3'b001;
        endcase
        BInvert = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_BEQ);
        CarryIn = BInvert;
        ALUSrc  = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI);
        if (op_q == OP_BEQ) begin
          PCWrite = Zero;
          PCSrc   = Zero;
        end
      end
      S_MEM: begin
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_q[3] == 1'b0);
        MemToReg = (op_q == OP_LW);
      end
      S_FAULT:  Fault = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Self-checking bench for cpu_multicycle_control: per-cycle expected state and
// control vector are queued as stimulus is driven and checked on the falling edge.
module tb_cpu_multicycle_control;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Opcode;
  logic       MemReady;
  logic       Zero;
  logic [2:0] AluSel;
  logic       BInvert, CarryIn, ALUSrc, RegDst, MemToReg, RegWrite;
  logic       MemRead, MemWrite, IRWrite, PCWrite, PCSrc, IllegalOp, Fault;
  logic [2:0] State;

  cpu_multicycle_control #(.MEM_WAIT_MAX(15), .WAIT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady), .Zero(Zero),
    .AluSel(AluSel), .BInvert(BInvert), .CarryIn(CarryIn), .ALUSrc(ALUSrc),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IllegalOp(IllegalOp), .Fault(Fault), .State(State)
  );

  always #5 Clock = ~Clock;

  // Control vector bit positions: AluSel[15:13] BInv12 Cin11 ALUSrc10 RegDst9
  // MemToReg8 RegWrite7 MemRead6 MemWrite5 IRWrite4 PCWrite3 PCSrc2 Illegal1 Fault0
  logic [15:0] outs_v;
  assign outs_v = {AluSel, BInvert, CarryIn, ALUSrc, RegDst, MemToReg, RegWrite,
                   MemRead, MemWrite, IRWrite, PCWrite, PCSrc, IllegalOp, Fault};

  localparam logic [15:0] V_NONE     = 16'h0000;
  localparam logic [15:0] V_FETCH_W  = 16'h0040;
  localparam logic [15:0] V_FETCH_OK = 16'h0058;
  localparam logic [15:0] V_ILLEGAL  = 16'h0002;
  localparam logic [15:0] V_IMM_EXEC = 16'h2400;
  localparam logic [15:0] V_MEMRD    = 16'h0040;
  localparam logic [15:0] V_MEMWR    = 16'h0020;
  localparam logic [15:0] V_WB_R     = 16'h0280;
  localparam logic [15:0] V_WB_I     = 16'h0080;
  localparam logic [15:0] V_WB_LW    = 16'h0180;
  localparam logic [15:0] V_FAULT    = 16'h0001;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] outs;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".state"}, 32'(State), 32'(e.st));
      check({e.tag, ".outs"}, 32'(outs_v), 32'(e.outs));
    end
  end

  function automatic logic [3:0] junk();
    return 4'($urandom_range(0, 15));
  endfunction

  // Drive one cycle of inputs (called at posedge+1) and queue what it must show.
  task automatic step(input logic [3:0] op, input logic mr, input logic z,
                      input logic [2:0] est, input logic [15:0] eout, input string tag);
    exp_t e;
    Opcode = op; MemReady = mr; Zero = z;
    e.st = est; e.outs = eout; e.tag = tag;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_seq();
    Reset = 1'b1;
    step(junk(), 1'b0, 1'b0, S_IDLE, V_NONE, "rst");
    step(junk(), 1'b1, 1'b1, S_IDLE, V_NONE, "rst");
    Reset = 1'b0;
    step(junk(), 1'b0, 1'b0, S_IDLE, V_NONE, "idle");
  endtask

  task automatic fetch(input int unsigned waits, input string tag);
    for (int unsigned i = 0; i < waits; i++)
      step(junk(), 1'b0, 1'b0, S_FETCH, V_FETCH_W, {tag, ".fetch_wait"});
    step(junk(), 1'b1, 1'b0, S_FETCH, V_FETCH_OK, {tag, ".fetch"});
  endtask

  task automatic rtype(input logic [3:0] op, input logic [2:0] alu, input logic inv,
                       input int unsigned fw, input string tag);
    fetch(fw, tag);
    step(op, 1'b1, 1'b0, S_DECODE, V_NONE, {tag, ".dec"});
    step(junk(), 1'b0, 1'b1, S_EXEC, {alu, inv, inv, 11'b0}, {tag, ".exec"});
    step(junk(), 1'b0, 1'b0, S_WB, V_WB_R, {tag, ".wb"});
  endtask

  task automatic addi(input string tag);
    fetch(0, tag);
    step(4'b1011, 1'b1, 1'b0, S_DECODE, V_NONE, {tag, ".dec"});
    step(junk(), 1'b1, 1'b0, S_EXEC, V_IMM_EXEC, {tag, ".exec"});
    step(junk(), 1'b1, 1'b0, S_WB, V_WB_I, {tag, ".wb"});
  endtask

  task automatic lw(input int unsigned mw, input string tag);
    fetch(0, tag);
    step(4'b1000, 1'b1, 1'b0, S_DECODE, V_NONE, {tag, ".dec"});
    step(junk(), 1'b0, 1'b0, S_EXEC, V_IMM_EXEC, {tag, ".exec"});
    for (int unsigned i = 0; i < mw; i++)
      step(junk(), 1'b0, 1'b0, S_MEM, V_MEMRD, {tag, ".mem_wait"});
    step(junk(), 1'b1, 1'b0, S_MEM, V_MEMRD, {tag, ".mem"});
    step(junk(), 1'b0, 1'b0, S_WB, V_WB_LW, {tag, ".wb"});
  endtask

  task automatic sw(input int unsigned mw, input string tag);
    fetch(0, tag);
    step(4'b1001, 1'b1, 1'b0, S_DECODE, V_NONE, {tag, ".dec"});
    step(junk(), 1'b0, 1'b0, S_EXEC, V_IMM_EXEC, {tag, ".exec"});
    for (int unsigned i = 0; i < mw; i++)
      step(junk(), 1'b0, 1'b0, S_MEM, V_MEMWR, {tag, ".mem_wait"});
    step(junk(), 1'b1, 1'b0, S_MEM, V_MEMWR, {tag, ".mem"});
  endtask

  task automatic beq(input logic z, input string tag);
    fetch(0, tag);
    step(4'b1010, 1'b1, 1'b0, S_DECODE, V_NONE, {tag, ".dec"});
    step(junk(), 1'b1, z, S_EXEC, z ? 16'h380C : 16'h3800, {tag, ".exec"});
  endtask

  task automatic illegal(input logic [3:0] op, input string tag);
    fetch(0, tag);
    step(op, 1'b1, 1'b0, S_DECODE, V_ILLEGAL, {tag, ".dec"});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Opcode = '0; MemReady = 1'b0; Zero = 1'b0;
    @(posedge Clock);
    #1;
    reset_seq();

    rtype(4'b0010, 3'b001, 1'b0, 0, "add");
    rtype(4'b0000, 3'b000, 1'b0, 0, "and");
    rtype(4'b0001, 3'b010, 1'b0, 1, "or");
    rtype(4'b0100, 3'b011, 1'b0, 0, "xor");
    rtype(4'b0011, 3'b001, 1'b1, 0, "sub");
    rtype(4'b0101, 3'b110, 1'b1, 2, "slt");
    rtype(4'b0110, 3'b111, 1'b0, 0, "sll");
    addi("addi");
    lw(0, "lw0");
    lw(3, "lw3");
    sw(0, "sw0");
    sw(2, "sw2");
    beq(1'b1, "beq_taken");
    beq(1'b0, "beq_not");
    illegal(4'b1100, "ill_c");
    illegal(4'b0111, "ill_7");
    illegal(4'b1101, "ill_d");
    // Ready arrives on the last tolerated wait cycle: normal decode, no fault.
    rtype(4'b0010, 3'b001, 1'b0, 15, "fetch_edge");

    // FETCH timeout: 16 stalled cycles, then sticky FAULT.
    for (int i = 0; i < 16; i++)
      step(junk(), 1'b0, 1'b0, S_FETCH, V_FETCH_W, "fetch_to");
    for (int i = 0; i < 4; i++)
      step(junk(), i[0], 1'b0, S_FAULT, V_FAULT, "fault_hold");
    reset_seq();

    // MEM timeout during a load.
    fetch(0, "mem_to");
    step(4'b1000, 1'b1, 1'b0, S_DECODE, V_NONE, "mem_to.dec");
    step(junk(), 1'b0, 1'b0, S_EXEC, V_IMM_EXEC, "mem_to.exec");
    for (int i = 0; i < 16; i++)
      step(junk(), 1'b0, 1'b0, S_MEM, V_MEMRD, "mem_to.mem");
    step(junk(), 1'b1, 1'b0, S_FAULT, V_FAULT, "mem_to.fault");
    reset_seq();

    // HALT holds for 20 cycles regardless of inputs.
    fetch(0, "halt");
    step(4'b1111, 1'b1, 1'b0, S_DECODE, V_NONE, "halt.dec");
    for (int i = 0; i < 20; i++)
      step(junk(), i[0], i[1], S_HALT, V_NONE, "halt.hold");
    reset_seq();

    // Asynchronous reset in the middle of a stalled store.
    fetch(0, "async");
    step(4'b1001, 1'b1, 1'b0, S_DECODE, V_NONE, "async.dec");
    step(junk(), 1'b0, 1'b0, S_EXEC, V_IMM_EXEC, "async.exec");
    step(junk(), 1'b0, 1'b0, S_MEM, V_MEMWR, "async.mem");
    MemReady = 1'b0;
    #2;
    check("async.memwrite_before", 32'(MemWrite), 32'd1);
    Reset = 1'b1;
    #1;
    check("async.memwrite_after", 32'(MemWrite), 32'd0);
    check("async.state_after", 32'(State), 32'(S_IDLE));
    check("async.outs_after", 32'(outs_v), 32'(V_NONE));
    @(posedge Clock);
    #1;
    step(junk(), 1'b1, 1'b0, S_IDLE, V_NONE, "async.rst");
    Reset = 1'b0;
    step(junk(), 1'b1, 1'b0, S_IDLE, V_NONE, "async.idle");
    rtype(4'b0010, 3'b001, 1'b0, 0, "after_async");

    @(negedge Clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
